// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared constants for the fetch unit and the controller that consumes it:
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - fetch_state_t    : fetch FSM state encodings
//   - instruction field bit positions (opcode, func3, func7)
//   - fetch_entry_t    : one buffered {instr, pc} pair
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // no response pending; issue or hold a request
        WAIT  = 2'd1,   // one accepted request whose response will be kept
        DRAIN = 2'd2    // one accepted request whose response will be dropped
    } fetch_state_t;

    localparam int OP_LSB    = 0;
    localparam int OP_MSB    = 6;
    localparam int FUNC3_LSB = 12;
    localparam int FUNC3_MSB = 14;
    localparam int FUNC7_LSB = 25;
    localparam int FUNC7_MSB = 31;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO of {instr, pc} pairs between instruction memory and decode.
// Flush is synchronous and takes priority over push.
//   clk, rst             : clock, asynchronous active-high reset
//   push, push_instr/pc  : write one entry (ignored when full without a pop)
//   pop                  : remove the head entry (ignored when empty)
//   flush                : empty the FIFO at the next edge
//   head_valid           : FIFO non-empty
//   head_instr, head_pc  : oldest entry
//   count                : current occupancy (0..2)
// -----------------------------------------------------------------------------
module fetch_buffer
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic        head_valid,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic [1:0]  count
);

    fetch_entry_t entries [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            // Push and pop together leave the occupancy unchanged.
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage has no reset; an entry is only visible once count says it
    // was written, and the top gates the decode outputs to zero when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            entries[wr_ptr] <= '{instr: push_instr, pc: push_pc};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_instr = entries[rd_ptr].instr;
    assign head_pc    = entries[rd_ptr].pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches word-aligned instructions with at most one outstanding memory
// request, buffers them in a 2-entry FIFO and presents the head to decode.
//   clk, rst                        : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/data             : response channel (after acceptance)
//   redirect, redirect_pc           : taken branch/jump from execute
//   dec_valid/ready                 : decode handshake
//   dec_instr, dec_pc, dec_pc_plus4 : head instruction and its address
//   dec_op, dec_func3, dec_func7    : raw field slices of dec_instr
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    output logic [6:0]  dec_op,
    output logic [2:0]  dec_func3,
    output logic [6:0]  dec_func7
);

    fetch_state_t state;
    logic [31:0]  pc;            // address of the next request to issue
    logic         stale;         // unaccepted request was overtaken by a redirect
    logic [31:0]  redirect_target;
    logic [31:0]  pc_after;
    logic [1:0]   fifo_count;
    logic [1:0]   count_after;
    logic         accept;
    logic         rsp_taken;
    logic         push;
    logic         pop;
    logic         idle_after;
    logic         issue;
    logic         head_valid;
    logic [31:0]  head_instr;
    logic [31:0]  head_pc;
    logic         unused_pc_bits;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc[1:0];

    assign accept    = imem_req_valid & imem_req_ready;
    // Responses only count while one is owed; anything else (e.g. a late
    // response to a request that was in flight at reset) is ignored.
    assign rsp_taken = imem_rsp_valid & (state != FETCH);
    assign push      = rsp_taken & (state == WAIT) & ~redirect;
    assign pop       = head_valid & dec_ready;

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pc_after = pc;
        if (redirect) begin
            pc_after = redirect_target;
        end else if (accept && !stale) begin
            pc_after = pc + 32'd4;   // wraps naturally at 2^32
        end

        count_after = fifo_count + {1'b0, push} - {1'b0, pop};
        if (redirect) begin
            count_after = 2'd0;
        end

        // Nothing pending or outstanding after this edge, so a new request may
        // start if the FIFO will still have room for its response.
        idle_after = rsp_taken | ((state == FETCH) & ~imem_req_valid);
        issue      = idle_after & (count_after < 2'd2);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            stale          <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= 32'd0;
        end else begin
            pc <= pc_after;
            case (state)
                FETCH: begin
                    if (accept) begin
                        imem_req_valid <= 1'b0;
                        stale          <= 1'b0;
                        state          <= (stale || redirect) ? DRAIN : WAIT;
                    end else if (imem_req_valid) begin
                        // Request and address stay put; only its fate changes.
                        if (redirect) stale <= 1'b1;
                    end else if (issue) begin
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= pc_after;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= FETCH;
                        if (issue) begin
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= pc_after;
                        end
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= FETCH;
                        if (issue) begin
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= pc_after;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // imem_req_addr still holds the accepted address while its response is owed.
    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (imem_rsp_data),
        .push_pc    (imem_req_addr),
        .pop        (pop),
        .flush      (redirect),
        .head_valid (head_valid),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (fifo_count)
    );

    assign dec_valid    = head_valid;
    assign dec_instr    = head_valid ? head_instr : 32'd0;
    assign dec_pc       = head_valid ? head_pc : 32'd0;
    assign dec_pc_plus4 = head_valid ? (head_pc + 32'd4) : 32'd0;
    assign dec_op       = dec_instr[OP_MSB:OP_LSB];
    assign dec_func3    = dec_instr[FUNC3_MSB:FUNC3_LSB];
    assign dec_func7    = dec_instr[FUNC7_MSB:FUNC7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomised memory/decode/redirect stimulus against a transaction-level
// model: an expected-instruction queue, the expected next fetch address and
// the fate (kept/stale) of the single pending and outstanding request.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic [6:0]  dec_op;
    logic [2:0]  dec_func3;
    logic [6:0]  dec_func7;

    instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4),
        .dec_op         (dec_op),
        .dec_func3      (dec_func3),
        .dec_func7      (dec_func7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model state
    ent_t        exp_q[$];
    logic [31:0] m_pc;
    bit          pend, pend_stale;
    logic [31:0] pend_addr;
    bit          outs, outs_stale;
    logic [31:0] outs_addr;
    int          outs_lat;

    // Stimulus knobs (percent probabilities, max response latency)
    int p_ready, p_dec, p_redir, max_lat;

    int checks, failures;
    int retired, stale_drops, rsp_redir_drops, wraps;
    bit did_mid_reset;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit roll(int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc       = TB_RESET_PC;
        pend       = 0;
        pend_stale = 0;
        outs       = 0;
        outs_stale = 0;
        outs_lat   = 0;
    endtask

    // Called just after a falling edge: check outputs, drive inputs, and
    // advance the model for the coming rising edge.
    task automatic step();
        ent_t h;
        bit   pop, rsp_now, accept;

        check("dec_valid", dec_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("dec_instr", dec_instr, h.instr);
            check("dec_pc", dec_pc, h.pc);
            check("dec_pc_plus4", dec_pc_plus4, h.pc + 32'd4);
            check("dec_op", dec_op, h.instr[6:0]);
            check("dec_func3", dec_func3, h.instr[14:12]);
            check("dec_func7", dec_func7, h.instr[31:25]);
        end
        if (imem_req_valid) begin
            if (!pend) begin
                check("req_credit", (exp_q.size() + (outs ? 1 : 0)) < 2, 1);
                check("req_addr", imem_req_addr, m_pc);
                pend      = 1;
                pend_addr = imem_req_addr;
            end else begin
                check("req_hold", imem_req_addr, pend_addr);
            end
        end else if (pend) begin
            check("req_dropped", imem_req_valid, 1);
            pend       = 0;
            pend_stale = 0;
        end

        dec_ready      = roll(p_dec);
        imem_req_ready = roll(p_ready);
        redirect       = roll(p_redir);
        redirect_pc    = (int'($urandom_range(3, 0)) == 0)
                         ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
        if (outs && outs_lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(outs_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (outs) outs_lat--;
        end

        pop = (exp_q.size() != 0) && dec_ready;
        if (pop) begin
            void'(exp_q.pop_front());
            retired++;
        end
        rsp_now = imem_rsp_valid && outs;
        if (rsp_now) begin
            if (outs_stale)    stale_drops++;
            else if (redirect) rsp_redir_drops++;
            else               exp_q.push_back(ent_t'{imem_rsp_data, outs_addr});
            outs = 0;
        end
        accept = imem_req_valid && imem_req_ready;
        if (accept) begin
            check("single_outstanding", outs, 0);
            outs       = 1;
            outs_stale = pend_stale || redirect;
            outs_addr  = pend_addr;
            outs_lat   = int'($urandom_range(max_lat - 1, 0));
            if (!pend_stale) begin
                if (pend_addr == 32'hFFFF_FFFC) wraps++;
                m_pc = m_pc + 32'd4;
            end
            pend       = 0;
            pend_stale = 0;
        end
        if (redirect) begin
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (pend) pend_stale = 1;
            if (outs) outs_stale = 1;
        end
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"}, imem_req_addr, 0);
        check({tag, "_dec_valid"}, dec_valid, 0);
        check({tag, "_dec_instr"}, dec_instr, 0);
        check({tag, "_dec_pc"}, dec_pc, 0);
        check({tag, "_dec_pc_plus4"}, dec_pc_plus4, 0);
        check({tag, "_dec_fields"}, {dec_op, dec_func3, dec_func7}, 0);
    endtask

    // Asserts rst asynchronously; optionally keeps a late response on the bus
    // through reset and the first cycles afterwards.
    task automatic reset_dut(bit late_rsp);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("reset");
        model_reset();
        imem_req_ready = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b0;
        imem_rsp_valid = late_rsp;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, TB_RESET_PC);
        @(negedge clk);
        check("late_rsp_ignored", dec_valid, 0);
        @(negedge clk);
        check("late_rsp_ignored2", dec_valid, 0);
        imem_rsp_valid = 1'b0;
    endtask

    task automatic set_knobs(int pr, int pd, int prd, int lat);
        p_ready = pr;
        p_dec   = pd;
        p_redir = prd;
        max_lat = lat;
    endtask

    task automatic run(int cycles, bit rst_mid);
        bit want = rst_mid;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (want && outs && !outs_stale && exp_q.size() == 1) begin
                reset_dut(1'b1);
                want          = 0;
                did_mid_reset = 1;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; retired = 0;
        stale_drops = 0; rsp_redir_drops = 0; wraps = 0; did_mid_reset = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b0;
        reset_dut(1'b0);

        // Zero-wait memory, decode always ready: 0, 4, 8, ... in order.
        set_knobs(100, 100, 0, 1);
        run(20, 0);
        check("zero_wait_progress", retired >= 8, 1);

        // Decode stalled: two buffered, no third request, outputs stable.
        set_knobs(100, 0, 0, 1);
        run(10, 0);
        @(negedge clk);
        check("stall_dec_valid", dec_valid, 1);
        check("stall_no_third_req", imem_req_valid, 0);
        set_knobs(100, 100, 0, 1);
        step();
        run(6, 0);

        // Random traffic with redirects, backpressure and variable latency.
        set_knobs(50, 60, 8, 4);
        run(3000, 0);
        set_knobs(20, 80, 15, 2);
        run(3000, 0);
        set_knobs(90, 30, 5, 3);
        run(3000, 1);
        set_knobs(70, 70, 10, 1);
        run(3000, 0);

        check("cov_retired", retired > 500, 1);
        check("cov_stale_drop", stale_drops > 0, 1);
        check("cov_rsp_redirect_drop", rsp_redir_drops > 0, 1);
        check("cov_pc_wrap", wraps > 0, 1);
        check("cov_mid_reset", did_mid_reset, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
